// File: rtl/feature_pin_serializer_pkg.sv
// Shared widths and types for the feature pin serializer slice.
package feature_pkg;

  localparam int FEATURE_WIDTH = 16;
  localparam int PIN_WIDTH     = 4;
  localparam int BEATS         = FEATURE_WIDTH / PIN_WIDTH;

  typedef logic signed [FEATURE_WIDTH-1:0] feature_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/feature_pin_serializer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push at full is taken only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/feature_pin_serializer.sv
// Regenerates feature validity from the conv-layer strobe, buffers features and
// emits them MSB-first on a narrow valid/ready pin bus.
//   state | meaning
//   IDLE  | nothing on the pins, waiting for a buffered feature
//   SEND  | shifter holds a feature, beats presented until the last is accepted
module feature_pin_serializer
  import feature_pkg::*;
#(
  parameter int FEATURE_WIDTH = feature_pkg::FEATURE_WIDTH,
  parameter int PIN_WIDTH     = feature_pkg::PIN_WIDTH,
  parameter int FIFO_DEPTH    = 8,
  parameter int PIPE_LATENCY  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          features_valid,
  input  logic [FEATURE_WIDTH-1:0]      feature_in,
  output logic [PIN_WIDTH-1:0]          pin_data,
  output logic                          pin_valid,
  input  logic                          pin_ready,
  output logic                          pin_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int BEATS = FEATURE_WIDTH / PIN_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (FEATURE_WIDTH % PIN_WIDTH != 0) begin : g_bad_width
    $error("FEATURE_WIDTH must be a multiple of PIN_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (PIPE_LATENCY < 1) begin : g_bad_latency
    $error("PIPE_LATENCY must be at least 1");
  end

  logic [PIPE_LATENCY-1:0]  vtap;
  logic                     push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FEATURE_WIDTH-1:0] fifo_rd_data;
  logic [FEATURE_WIDTH-1:0] shifter;
  logic [BCW-1:0]           beat_cnt;
  logic                     last_beat;
  ser_state_t               state;

  // The post-processing stage has no valid; the strobe is delayed to line up with its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vtap <= '0;
    end else begin
      vtap <= (vtap << 1) | PIPE_LATENCY'(features_valid);
    end
  end

  assign push = vtap[PIPE_LATENCY-1];

  sync_fifo #(
    .WIDTH (FEATURE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (fifo_pop),
    .wr_data (feature_in),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign last_beat = (beat_cnt == BCW'(BEATS - 1));
  assign pin_valid = (state == SEND);
  assign pin_last  = (state == SEND) && last_beat;
  assign pin_data  = shifter[FEATURE_WIDTH-1 -: PIN_WIDTH];

  // A pop either starts a feature from IDLE or reloads right behind an accepted last beat.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE) begin
        fifo_pop = 1'b1;
      end else if (pin_ready && last_beat) begin
        fifo_pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shifter  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            shifter  <= fifo_rd_data;
            beat_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (pin_ready) begin
            if (!last_beat) begin
              shifter  <= shifter << PIN_WIDTH;
              beat_cnt <= beat_cnt + 1'b1;
            end else if (fifo_pop) begin
              shifter  <= fifo_rd_data;
              beat_cnt <= '0;
            end else begin
              shifter  <= '0;
              beat_cnt <= '0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          shifter  <= '0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

endmodule
